debug_step_unit: RTL
====================

DEBUG_STEP_UNIT -- requirements
Module: debug_step_unit

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset, with ports as follows (clock and reset first).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  host command byte present.
REQ-005 cmd_byte  input  8  command code.
REQ-006 cmd_ready  output  1  unit can accept a command.
REQ-007 clkEnable  output  1  advance enable for the Pipeline; registered.
REQ-008 instruction  input  32  Pipeline IF-stage instruction.
REQ-009 PC_IFID  input  10  Pipeline IF/ID PC.
REQ-010 Registers  input  1024  register file; reg i = Registers[32*i+31:32*i].
REQ-011 tx_valid  output  1  dump byte present.
REQ-012 tx_data  output  8  dump byte.
REQ-013 tx_ready  input  1  consumer accepts the dump byte.
REQ-014 halted  output  1  sticky halt flag.
REQ-015 Parameter HALT_WORD, default 32'hFFFF_FFFF, the instruction that stops continuous run.

Function
REQ-016 SHALL implement states IDLE, RUN, STEP and DUMP.
REQ-017 A command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE with reset low.
REQ-018 Command 0x43 'C' SHALL go IDLE->RUN, or IDLE->DUMP if halted=1.
REQ-019 Command 0x53 'S' SHALL go IDLE->STEP, or IDLE->DUMP if halted=1.
REQ-020 Command 0x44 'D' SHALL go IDLE->DUMP.
REQ-021 Any other accepted byte SHALL be consumed with the state remaining IDLE.
REQ-022 clkEnable SHALL be 1 exactly in cycles where the registered state is RUN or STEP, and 0 otherwise.
REQ-023 STEP SHALL last exactly one cycle and then go to DUMP, giving exactly one clkEnable pulse per 'S'.
REQ-024 In RUN, if instruction == HALT_WORD on any cycle, the next state SHALL be DUMP and halted SHALL be set to 1 on that same edge.
REQ-025 In RUN, if instruction != HALT_WORD, the state SHALL remain RUN.
REQ-026 A HALT_WORD seen in STEP SHALL also set halted.
REQ-027 cycle_cnt (32-bit, internal) SHALL increment on every cycle with clkEnable=1 and wrap 0xFFFF_FFFF->0.
REQ-028 DUMP SHALL send 134 bytes with index 0..133: bytes 0-1 = {6'b0, PC_IFID}, MSB first; bytes 2-5 = cycle_cnt, MSB first; bytes 6-133 = reg0..reg31, each MSB first.
REQ-029 In DUMP, tx_valid SHALL be 1 and tx_data SHALL be the byte at the current index.
REQ-030 tx_data SHALL be held stable until tx_valid && tx_ready, after which the index advances by one.
REQ-031 Dump sources SHALL be read live; they are stable because clkEnable=0 in DUMP.
REQ-032 On acceptance of byte 133, the state SHALL return to IDLE and the index SHALL clear to 0.
REQ-033 When tx_ready is held 0, the unit SHALL stall indefinitely with no byte lost or repeated.
REQ-034 cmd_valid arriving outside IDLE SHALL be left pending, not dropped, since cmd_ready=0.

Reset
REQ-035 Reset asserted in any state, including mid-RUN or mid-DUMP, SHALL on the next edge force: state=IDLE, clkEnable=0, tx_valid=0, index=0, cycle_cnt=0, halted=0.
REQ-036 While reset=1, cmd_ready SHALL be 0; the first cycle after deassertion, cmd_ready SHALL be 1.

Verification
REQ-037 Reset, then 'D' with Registers=0, PC_IFID=10'h3FF and tx_ready=1 -> 134 bytes: 03 FF 00 00 00 00 then 128 x 00; cmd_ready returns to 1.
REQ-038 Reset, then 'S' three times -> clkEnable pulses exactly once per command; the cycle_cnt bytes in the three dumps read 1, 2, 3.
REQ-039 'C' with instruction driven to HALT_WORD on the 10th RUN cycle -> clkEnable high for 10 cycles, halted=1, dump shows cycle_cnt=10; a following 'C' gives a dump only, with no clkEnable.
REQ-040 During a dump, tx_ready toggles every other cycle with reg5=32'hDEADBEEF -> bytes 26-29 are DE AD BE EF; total 134 bytes, each exactly once.
REQ-041 Reset pulsed at byte 50 of a dump -> tx_valid=0 next cycle, cycle_cnt=0; a following 'D' restarts at byte 0.
REQ-042 Command 0x41 -> no state change, no clkEnable, cmd_ready stays 1.

Source files
------------

// File: rtl/debug_step_unit.sv
// debug_step_unit: host-driven run/step/halt controller for a pipelined core.
// It drives the pipeline advance enable and streams a 134-byte state dump (PC, cycle count, register file).
`default_nettype none

module debug_step_unit #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_byte,
  output logic          cmd_ready,
  output logic          clkEnable,
  input  logic [31:0]   instruction,
  input  logic [9:0]    PC_IFID,
  input  logic [1023:0] Registers,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          halted
);

  localparam logic [7:0] c_CMD_CONT = 8'h43;
  localparam logic [7:0] c_CMD_STEP = 8'h53;
  localparam logic [7:0] c_CMD_DUMP = 8'h44;
  localparam logic [7:0] c_LAST_IDX = 8'd133;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_clk_en;
  logic        r_tx_valid;
  logic        r_halted;
  logic [7:0]  r_idx;
  logic [31:0] r_cycle_cnt;

  logic [6:0]  w_reg_off;
  logic [31:0] w_reg_word;
  logic [7:0]  w_tx_byte;
  logic        w_halt_seen;

  assign w_halt_seen = (instruction == HALT_WORD);

  // Byte offset into the register area; the 7-bit wrap keeps indices 128..133 correct.
  assign w_reg_off  = r_idx[6:0] - 7'd6;
  assign w_reg_word = Registers[{w_reg_off[6:2], 5'd0} +: 32];

  always_comb begin
    w_tx_byte = 8'd0;
    case (r_idx)
      8'd0: w_tx_byte = {6'b0, PC_IFID[9:8]};
      8'd1: w_tx_byte = PC_IFID[7:0];
      8'd2: w_tx_byte = r_cycle_cnt[31:24];
      8'd3: w_tx_byte = r_cycle_cnt[23:16];
      8'd4: w_tx_byte = r_cycle_cnt[15:8];
      8'd5: w_tx_byte = r_cycle_cnt[7:0];
      default: begin
        case (w_reg_off[1:0])
          2'd0: w_tx_byte = w_reg_word[31:24];
          2'd1: w_tx_byte = w_reg_word[23:16];
          2'd2: w_tx_byte = w_reg_word[15:8];
          default: w_tx_byte = w_reg_word[7:0];
        endcase
      end
    endcase
  end

  // clkEnable and tx_valid are set on the same edge as the state they belong to,
  // so they always match the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_clk_en    <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_halted    <= 1'b0;
      r_idx       <= 8'd0;
      r_cycle_cnt <= 32'd0;
    end else begin
      if (r_clk_en) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if ((cmd_byte == c_CMD_DUMP) ||
                (((cmd_byte == c_CMD_CONT) || (cmd_byte == c_CMD_STEP)) && r_halted)) begin
              r_state    <= ST_DUMP;
              r_tx_valid <= 1'b1;
            end else if (cmd_byte == c_CMD_CONT) begin
              r_state  <= ST_RUN;
              r_clk_en <= 1'b1;
            end else if (cmd_byte == c_CMD_STEP) begin
              r_state  <= ST_STEP;
              r_clk_en <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_halt_seen) begin
            r_state    <= ST_DUMP;
            r_clk_en   <= 1'b0;
            r_tx_valid <= 1'b1;
            r_halted   <= 1'b1;
          end
        end
        ST_STEP: begin
          if (w_halt_seen) begin
            r_halted <= 1'b1;
          end
          r_state    <= ST_DUMP;
          r_clk_en   <= 1'b0;
          r_tx_valid <= 1'b1;
        end
        default: begin
          if (tx_ready) begin
            if (r_idx == c_LAST_IDX) begin
              r_state    <= ST_IDLE;
              r_tx_valid <= 1'b0;
              r_idx      <= 8'd0;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign clkEnable = r_clk_en;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = w_tx_byte;
  assign halted    = r_halted;

endmodule

`default_nettype wire
